// File: rtl/digit_scan_demux.sv
// Registered 1-to-N_CH digit-enable demultiplexer for the multiplexed display.
// Auto-scans channels from an internal prescaler or follows an external select.
module digit_scan_demux #(
    parameter int N_CH       = 4,
    parameter int PRESCALE   = 50000,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int SEL_W     = (N_CH <= 2) ? 1 : $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             auto_mode,
    input  logic [SEL_W-1:0] sel_in,
    input  logic [N_CH-1:0]  blank_mask,
    output logic [N_CH-1:0]  d_out,
    output logic [SEL_W-1:0] cur_sel,
    output logic             frame_tick
);

    localparam int               PS_W     = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  IDLE     = {N_CH{ACTIVE_LOW}};

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [N_CH-1:0]  d_out_q, d_out_d;
    logic             frame_tick_q, frame_tick_d;

    logic             step;
    logic             wrap;
    logic [N_CH-1:0]  raw;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        presc_d      = '0;
        idx_d        = idx_q;
        raw          = '0;
        step         = auto_mode && (presc_q == PS_LAST);
        wrap         = step && (idx_q == LAST_IDX);

        if (auto_mode) begin
            presc_d = step ? '0 : presc_q + PS_W'(1);
            if (step) begin
                idx_d = wrap ? '0 : idx_q + SEL_W'(1);
            end
        end else if (sel_in <= LAST_IDX) begin
            // Out-of-range selects (non-power-of-two N_CH) keep the previous channel.
            idx_d = sel_in;
        end

        // Outputs derive from idx_d so d_out, cur_sel and frame_tick always agree.
        if (en && !blank_mask[idx_d]) begin
            raw[idx_d] = 1'b1;
        end
        d_out_d      = ACTIVE_LOW ? ~raw : raw;
        frame_tick_d = wrap;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            d_out_q      <= IDLE;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            d_out_q      <= d_out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign d_out      = d_out_q;
    assign cur_sel    = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_digit_scan_demux.sv
// Directed bench for digit_scan_demux: three instances cover the 4-channel,
// 5-channel active-low and long-dwell configurations.
module tb_digit_scan_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: N_CH=4, PRESCALE=3, active-high
    logic       rst_a = 1'b1, en_a = 1'b0, auto_a = 1'b0;
    logic [1:0] sel_a = '0;
    logic [3:0] blank_a = '0;
    logic [3:0] dout_a;
    logic [1:0] cur_a;
    logic       ft_a;

    // Instance B: N_CH=5, PRESCALE=1, active-low
    logic       rst_b = 1'b1, en_b = 1'b0, auto_b = 1'b0;
    logic [2:0] sel_b = '0;
    logic [4:0] blank_b = '0;
    logic [4:0] dout_b;
    logic [2:0] cur_b;
    logic       ft_b;

    // Instance C: N_CH=4, PRESCALE=5, active-high
    logic       rst_c = 1'b1, en_c = 1'b0, auto_c = 1'b0;
    logic [1:0] sel_c = '0;
    logic [3:0] blank_c = '0;
    logic [3:0] dout_c;
    logic [1:0] cur_c;
    logic       ft_c;

    digit_scan_demux #(.N_CH(4), .PRESCALE(3), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .auto_mode(auto_a), .sel_in(sel_a),
        .blank_mask(blank_a), .d_out(dout_a), .cur_sel(cur_a), .frame_tick(ft_a)
    );

    digit_scan_demux #(.N_CH(5), .PRESCALE(1), .ACTIVE_LOW(1'b1)) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .auto_mode(auto_b), .sel_in(sel_b),
        .blank_mask(blank_b), .d_out(dout_b), .cur_sel(cur_b), .frame_tick(ft_b)
    );

    digit_scan_demux #(.N_CH(4), .PRESCALE(5), .ACTIVE_LOW(1'b0)) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .auto_mode(auto_c), .sel_in(sel_c),
        .blank_mask(blank_c), .d_out(dout_c), .cur_sel(cur_c), .frame_tick(ft_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds A in reset, checks outputs, then asserts reset mid-cycle while scanning.
    task automatic test_reset();
        en_a   = 1'b1;
        auto_a = 1'b1;
        tick();
        checks++;
        if (dout_a !== 4'b0000 || cur_a !== 2'd0 || ft_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold d=%b/0000 cur=%0d/0 ft=%b/0", dout_a, cur_a, ft_a);
        end
        rst_a = 1'b0;
        repeat (4) tick();
        checks++;
        if (dout_a !== 4'b0010 || cur_a !== 2'd1) begin
            failures++;
            $display("FAIL pre_reset d=%b/0010 cur=%0d/1", dout_a, cur_a);
        end
        #3 rst_a = 1'b1;
        #1;
        checks++;
        if (dout_a !== 4'b0000 || cur_a !== 2'd0 || ft_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_async d=%b/0000 cur=%0d/0 ft=%b/0", dout_a, cur_a, ft_a);
        end
        tick();
        rst_a = 1'b0;
    endtask

    // Three scan frames straight after reset release; frame_tick every 12 cycles.
    task automatic test_scan_wrap();
        int         ei;
        logic [3:0] ed;
        logic       ef;
        for (int k = 1; k <= 36; k++) begin
            tick();
            ei = (k / 3) % 4;
            ed = 4'b0001 << ei;
            ef = (k % 12 == 0);
            checks++;
            if (dout_a !== ed || cur_a !== ei[1:0] || ft_a !== ef) begin
                failures++;
                $display("FAIL scan k=%0d d=%b/%b cur=%0d/%0d ft=%b/%b",
                         k, dout_a, ed, cur_a, ei, ft_a, ef);
            end
        end
    endtask

    // Channel 2 blanked for one frame, then en low for a full frame.
    task automatic test_blank_en();
        int         ei;
        logic [3:0] ed;
        logic       ef;
        rst_a   = 1'b1;
        blank_a = 4'b0100;
        en_a    = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            ei = (k / 3) % 4;
            ed = (k <= 12 && ei != 2) ? (4'b0001 << ei) : 4'b0000;
            ef = (k % 12 == 0);
            checks++;
            if (dout_a !== ed || cur_a !== ei[1:0] || ft_a !== ef) begin
                failures++;
                $display("FAIL blank_en k=%0d d=%b/%b cur=%0d/%0d ft=%b/%b",
                         k, dout_a, ed, cur_a, ei, ft_a, ef);
            end
            if (k == 12) en_a = 1'b0;
        end
        en_a    = 1'b1;
        blank_a = 4'b0000;
    endtask

    // Five channels, active-low, manual selects including illegal ones, then auto.
    task automatic test_nonpow2();
        logic [2:0] sel_v [6]   = '{3'd4, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2};
        logic [4:0] blk_v [6]   = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00000};
        logic [4:0] exp_d [6]   = '{5'b01111, 5'b10111, 5'b10111, 5'b10111, 5'b11111, 5'b11011};
        logic [2:0] exp_c [6]   = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2};
        logic [4:0] auto_d [4]  = '{5'b10111, 5'b01111, 5'b11110, 5'b11101};
        logic [2:0] auto_c [4]  = '{3'd3, 3'd4, 3'd0, 3'd1};
        logic       auto_f [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        tick();
        checks++;
        if (dout_b !== 5'b11111 || cur_b !== 3'd0 || ft_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_low d=%b/11111 cur=%0d/0 ft=%b/0", dout_b, cur_b, ft_b);
        end
        rst_b  = 1'b0;
        en_b   = 1'b1;
        auto_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel_b   = sel_v[i];
            blank_b = blk_v[i];
            tick();
            checks++;
            if (dout_b !== exp_d[i] || cur_b !== exp_c[i] || ft_b !== 1'b0) begin
                failures++;
                $display("FAIL manual sel=%0d d=%b/%b cur=%0d/%0d ft=%b/0",
                         sel_v[i], dout_b, exp_d[i], cur_b, exp_c[i], ft_b);
            end
        end
        sel_b = 3'd3;
        tick();
        auto_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (dout_b !== auto_d[i] || cur_b !== auto_c[i] || ft_b !== auto_f[i]) begin
                failures++;
                $display("FAIL auto5 step=%0d d=%b/%b cur=%0d/%0d ft=%b/%b",
                         i, dout_b, auto_d[i], cur_b, auto_c[i], ft_b, auto_f[i]);
            end
        end
    endtask

    // Manual override two cycles into channel 1, then a full dwell on channel 3.
    task automatic test_mode_switch();
        en_c   = 1'b1;
        auto_c = 1'b1;
        tick();
        rst_c = 1'b0;
        repeat (6) tick();
        checks++;
        if (dout_c !== 4'b0010 || cur_c !== 2'd1) begin
            failures++;
            $display("FAIL pre_switch d=%b/0010 cur=%0d/1", dout_c, cur_c);
        end
        auto_c = 1'b0;
        sel_c  = 2'd3;
        tick();
        checks++;
        if (dout_c !== 4'b1000 || cur_c !== 2'd3 || ft_c !== 1'b0) begin
            failures++;
            $display("FAIL to_manual d=%b/1000 cur=%0d/3 ft=%b/0", dout_c, cur_c, ft_c);
        end
        auto_c = 1'b1;
        sel_c  = 2'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (k <= 4) begin
                if (dout_c !== 4'b1000 || cur_c !== 2'd3 || ft_c !== 1'b0) begin
                    failures++;
                    $display("FAIL dwell3 k=%0d d=%b/1000 cur=%0d/3 ft=%b/0", k, dout_c, cur_c, ft_c);
                end
            end else begin
                if (dout_c !== 4'b0001 || cur_c !== 2'd0 || ft_c !== (k == 5)) begin
                    failures++;
                    $display("FAIL wrap_after_manual k=%0d d=%b/0001 cur=%0d/0 ft=%b/%b",
                             k, dout_c, cur_c, ft_c, (k == 5));
                end
            end
        end
    endtask

    // Reset hits channel 2, cycle 1 of its dwell; scan restarts with a full dwell.
    task automatic test_reset_mid();
        int         ei;
        logic [3:0] ed;
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        repeat (11) tick();
        checks++;
        if (dout_c !== 4'b0100 || cur_c !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset_mid d=%b/0100 cur=%0d/2", dout_c, cur_c);
        end
        #3 rst_c = 1'b1;
        #1;
        checks++;
        if (dout_c !== 4'b0000 || cur_c !== 2'd0 || ft_c !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid d=%b/0000 cur=%0d/0 ft=%b/0", dout_c, cur_c, ft_c);
        end
        tick();
        rst_c = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            ei = (k / 5) % 4;
            ed = 4'b0001 << ei;
            checks++;
            if (dout_c !== ed || cur_c !== ei[1:0] || ft_c !== 1'b0) begin
                failures++;
                $display("FAIL restart k=%0d d=%b/%b cur=%0d/%0d ft=%b/0",
                         k, dout_c, ed, cur_c, ei, ft_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_wrap();
        test_blank_en();
        test_nonpow2();
        test_mode_switch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
